// File: rtl/add32_stream_ctrl.sv
// Valid/ready stream wrapper around a fixed-latency, non-stallable pipelined 32-bit adder.
// In-flight beats are tracked by a valid shift register; results land in a credit-guarded FIFO.
module add32_stream_ctrl #(
    parameter int LAT   = 5,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_cin,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_s,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_cout,
    output logic [2:0]  inflight,
    output logic        ovf_err
);
    localparam int AW = $clog2(DEPTH);

    // Handshake: a beat transfers on an edge where valid & ready are both high;
    // ready never depends on valid, and a source holds valid/data until transfer.
    logic           acc;
    logic           push;
    logic           pop;
    logic           full;
    logic [LAT-1:0] vsr;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [AW+1:0]  credits_used;
    logic [32:0]    mem [DEPTH];

    assign add_a   = in_a;
    assign add_b   = in_b;
    assign add_cin = in_cin;

    assign acc  = in_valid & in_ready;
    assign push = vsr[LAT-1];
    assign full = (count == (AW+1)'(DEPTH));
    assign pop  = out_valid & out_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + 3'(vsr[i]);
        end
    end

    // A pop in this cycle is deliberately not credited until the next one.
    assign credits_used = (AW+2)'(count) + (AW+2)'(inflight);
    assign in_ready     = credits_used < (AW+2)'(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsr <= '0;
        end else begin
            vsr <= {vsr[LAT-2:0], acc};
        end
    end

    // Storage is intentionally unreset; the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push && (!full || pop)) begin
            mem[wr_ptr] <= {add_cout, add_s};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push && (!full || pop)) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && full && !pop) begin
                ovf_err <= 1'b1;
            end
            case ({push && (!full || pop), pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid = (count != '0);
    assign out_sum   = out_valid ? mem[rd_ptr][31:0] : 32'd0;
    assign out_cout  = out_valid ? mem[rd_ptr][32]   : 1'b0;
endmodule
